pipeline_sequencer: RTL and testbench
=====================================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 clk  input  1  single system clock; all state updates on posedge clk.
REQ-002 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-003 ins_in  input  20  instruction word read combinationally from instruction memory at address pc.
REQ-004 hold  input  1  external freeze; 1 = no state, pc or ins_out change this cycle.
REQ-005 br_taken  input  1  conditional-jump outcome from execute stage; valid in state BR_WAIT2.
REQ-006 br_target  input  8  conditional-jump target address; valid with br_taken.
REQ-007 pc  output  8  instruction memory address (registered).
REQ-008 ins_out  output  20  registered instruction issued to the dependency check stage.
REQ-009 stall  output  1  registered; 1 while ins_out carries an injected NOP.
REQ-010 state_o  output  2  current state: 00 RUN, 01 LD_BUB, 10 BR_WAIT1, 11 BR_WAIT2.
REQ-011 stall_count  output  8  injected-bubble counter (see Configuration).

Function
REQ-012 Opcode = ins_in[19:15]; JMP = 11000, CJMP = 111xx, LOAD = 10100; NOP word = 20'h00000.
REQ-013 RUN, non-special opcode: ins_out <= ins_in, stall <= 0, pc <= pc+1 (mod 256, 255 -> 0), stay RUN.
REQ-014 RUN, JMP: ins_out <= ins_in, stall <= 0, pc <= ins_in[7:0], stay RUN; no bubble.
REQ-015 RUN, LOAD: ins_out <= ins_in, stall <= 0, pc <= pc+1, next state LD_BUB.
REQ-016 LD_BUB: ins_out <= NOP, stall <= 1, pc held, next state RUN; load-use distance is exactly one bubble.
REQ-017 Back-to-back LOADs: each LOAD is followed by its own single bubble (LOAD, NOP, LOAD, NOP).
REQ-018 RUN, CJMP: ins_out <= ins_in, stall <= 0, pc held, next state BR_WAIT1.
REQ-019 BR_WAIT1: ins_out <= NOP, stall <= 1, pc held, next state BR_WAIT2.
REQ-020 BR_WAIT2: ins_out <= NOP, stall <= 1, pc <= br_taken ? br_target : pc+1, next state RUN.
REQ-021 br_taken/br_target are ignored in every state other than BR_WAIT2.
REQ-022 hold = 1: state, pc, ins_out, stall and stall_count all retain their values; hold has priority over every transition, including BR_WAIT2 resolution.
REQ-023 hold = 1 in BR_WAIT2: resolution is deferred; br_taken/br_target are sampled on the first cycle hold = 0.
REQ-024 Issue latency: an instruction present on ins_in in RUN appears on ins_out one cycle later.
REQ-025 Exactly one ins_out word is produced per non-held cycle; no instruction is dropped or duplicated.

Reset
REQ-026 While reset = 0: pc = 8'h00, ins_out = NOP, stall = 0, state = RUN, stall_count = 0.
REQ-027 Reset asserted mid-LD_BUB or mid-BR_WAIT aborts the sequence; the first cycle after release fetches address 0 in RUN.
REQ-028 Release of reset takes effect on the first posedge clk after reset returns to 1.

Configuration
REQ-029 Macro STALL_COUNTER_EN defined: stall_count increments by 1 on every cycle in which a NOP is injected (not held), saturates at 8'hFF, and clears only on reset.
REQ-030 STALL_COUNTER_EN undefined: no counter register exists and stall_count is tied to 8'h00; all other behaviour is identical.

Verification
REQ-031 Reset release, memory of ADD words at 0..3 -> pc 0,1,2,3,4 on successive cycles; ins_out lags one cycle; stall = 0 throughout.
REQ-032 JMP at pc 5 with ins_in[7:0] = 8'h40 -> next pc = 8'h40; ins_out shows the JMP word, then word at 0x40; no NOP.
REQ-033 LOAD at pc 2, LOAD at pc 3 -> ins_out: LOAD, NOP, LOAD, NOP; stall = 0,1,0,1; pc 3,3,4,4 then 5; stall_count = 2 (macro on), 0 (macro off).
REQ-034 CJMP at pc 7, br_taken = 1, br_target = 8'h20 in BR_WAIT2 -> two NOPs, then pc = 8'h20; repeat with br_taken = 0 -> pc = 8'h08.
REQ-035 CJMP with hold = 1 for 3 cycles in BR_WAIT2 -> state stays BR_WAIT2, pc stays 7; resolves on first cycle hold = 0.
REQ-036 pc = 8'hFF with an ADD word -> pc wraps to 8'h00; reset pulsed during LD_BUB -> pc = 0, state RUN, ins_out = NOP immediately.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
//   Fetch/issue sequencer sitting in front of the dependency check stage.
//   Issues one instruction word per non-held cycle. It injects a single NOP
//   bubble after a LOAD and two NOPs while a conditional jump resolves.
//   Unconditional jumps redirect pc directly, without a bubble.
//
// Ports
//   clk          system clock, all state on posedge
//   reset        asynchronous, active-low reset
//   ins_in[19:0] instruction word fetched from instruction memory at pc
//   hold         freeze: no state/pc/ins_out/stall/stall_count change
//   br_taken     conditional-jump outcome, sampled only in BR_WAIT2
//   br_target    conditional-jump target address, valid with br_taken
//   pc[7:0]      instruction memory address (registered)
//   ins_out      registered instruction to the dependency check stage
//   stall        1 while ins_out carries an injected NOP
//   state_o      00 RUN, 01 LD_BUB, 10 BR_WAIT1, 11 BR_WAIT2
//   stall_count  injected-bubble counter
//
// Build option
//   STALL_COUNTER_EN  when defined, stall_count is a saturating count of
//                     injected NOPs that clears only on reset. When it is
//                     undefined, stall_count is tied to zero.
module pipeline_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] ins_in,
  input  logic        hold,
  input  logic        br_taken,
  input  logic [7:0]  br_target,
  output logic [7:0]  pc,
  output logic [19:0] ins_out,
  output logic        stall,
  output logic [1:0]  state_o,
  output logic [7:0]  stall_count
);

  localparam logic [1:0] RUN      = 2'b00;
  localparam logic [1:0] LD_BUB   = 2'b01;
  localparam logic [1:0] BR_WAIT1 = 2'b10;
  localparam logic [1:0] BR_WAIT2 = 2'b11;

  localparam logic [19:0] NOP_WORD = 20'h00000;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [7:0]  pc_next;
  logic [19:0] ins_next;
  logic        stall_next;

  logic [4:0]  opcode;
  logic        is_jmp;
  logic        is_cjmp;
  logic        is_load;

  assign opcode  = ins_in[19:15];
  assign is_jmp  = (opcode == 5'b11000);
  assign is_cjmp = (opcode[4:2] == 3'b111);
  assign is_load = (opcode == 5'b10100);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ins_next   = ins_out;
    stall_next = stall;
    case (state)
      RUN: begin
        ins_next   = ins_in;
        stall_next = 1'b0;
        if (is_jmp) begin
          pc_next    = ins_in[7:0];
          state_next = RUN;
        end else if (is_cjmp) begin
          // pc is held so the fall-through address is still pc+1 at resolution
          pc_next    = pc;
          state_next = BR_WAIT1;
        end else if (is_load) begin
          pc_next    = pc + 8'd1;
          state_next = LD_BUB;
        end else begin
          pc_next    = pc + 8'd1;
          state_next = RUN;
        end
      end
      LD_BUB: begin
        ins_next   = NOP_WORD;
        stall_next = 1'b1;
        state_next = RUN;
      end
      BR_WAIT1: begin
        ins_next   = NOP_WORD;
        stall_next = 1'b1;
        state_next = BR_WAIT2;
      end
      default: begin
        ins_next   = NOP_WORD;
        stall_next = 1'b1;
        pc_next    = br_taken ? br_target : (pc + 8'd1);
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      pc      <= '0;
      ins_out <= NOP_WORD;
      stall   <= 1'b0;
    end else if (!hold) begin
      state   <= state_next;
      pc      <= pc_next;
      ins_out <= ins_next;
      stall   <= stall_next;
    end
  end

  assign state_o = state;

`ifdef STALL_COUNTER_EN
  logic [7:0] bubble_count;

  // A NOP is injected exactly in the non-RUN states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_count <= '0;
    end else if (!hold && (state != RUN) && (bubble_count != 8'hFF)) begin
      bubble_count <= bubble_count + 8'd1;
    end
  end

  assign stall_count = bubble_count;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;

  logic        clk;
  logic        reset;
  logic [19:0] ins_in;
  logic        hold;
  logic        br_taken;
  logic [7:0]  br_target;
  logic [7:0]  pc;
  logic [19:0] ins_out;
  logic        stall;
  logic [1:0]  state_o;
  logic [7:0]  stall_count;

  logic [19:0] mem [256];

  int unsigned checks;
  int unsigned failures;

`ifdef STALL_COUNTER_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam logic [1:0] S_RUN = 2'b00;
  localparam logic [1:0] S_LD  = 2'b01;
  localparam logic [1:0] S_B1  = 2'b10;
  localparam logic [1:0] S_B2  = 2'b11;

  localparam logic [19:0] A0   = 20'h08000;
  localparam logic [19:0] A1   = 20'h08001;
  localparam logic [19:0] LD2  = 20'hA0002;
  localparam logic [19:0] LD3  = 20'hA0003;
  localparam logic [19:0] A4   = 20'h08004;
  localparam logic [19:0] J40  = 20'hC0040;
  localparam logic [19:0] A40  = 20'h08040;
  localparam logic [19:0] J07  = 20'hC0007;
  localparam logic [19:0] CJ   = 20'hE0007;
  localparam logic [19:0] AFF  = 20'h080FF;
  localparam logic [19:0] NOP  = 20'h00000;

  pipeline_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .ins_in      (ins_in),
    .hold        (hold),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .pc          (pc),
    .ins_out     (ins_out),
    .stall       (stall),
    .state_o     (state_o),
    .stall_count (stall_count)
  );

  assign ins_in = mem[pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_pc, input logic [19:0] e_ins,
                           input logic e_stall, input logic [1:0] e_state, input logic [7:0] e_cnt);
    check({tag, ".pc"}, {24'h0, pc}, {24'h0, e_pc});
    check({tag, ".ins"}, {12'h0, ins_out}, {12'h0, e_ins});
    check({tag, ".stall"}, {31'h0, stall}, {31'h0, e_stall});
    check({tag, ".state"}, {30'h0, state_o}, {30'h0, e_state});
    check({tag, ".cnt"}, {24'h0, stall_count}, {24'h0, (CNT_ON ? e_cnt : 8'h00)});
  endtask

  // Advance one clock and check the registered outputs just after the edge.
  task automatic cyc(input string tag, input logic [7:0] e_pc, input logic [19:0] e_ins,
                     input logic e_stall, input logic [1:0] e_state, input logic [7:0] e_cnt);
    @(posedge clk);
    #1;
    check_all(tag, e_pc, e_ins, e_stall, e_state, e_cnt);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    hold      = 1'b0;
    br_taken  = 1'b1;
    br_target = 8'h99;
    for (int i = 0; i < 256; i++) mem[i] = 20'h08000 | 20'(i);
    mem[2]    = LD2;
    mem[3]    = LD3;
    mem[5]    = J40;
    mem[8'h41] = J07;
    mem[7]    = CJ;
    mem[8]    = J07;
    mem[8'h20] = J07;

    #2;
    check_all("rst", 8'h00, NOP, 1'b0, S_RUN, 8'd0);
    @(negedge clk);
    reset = 1'b1;

    // sequential fetch, ins_out lags pc by one cycle
    cyc("c1",  8'h01, A0,  1'b0, S_RUN, 8'd0);
    cyc("c2",  8'h02, A1,  1'b0, S_RUN, 8'd0);
    // back-to-back loads, one bubble each; br_taken=1 here must be ignored
    cyc("c3",  8'h03, LD2, 1'b0, S_LD,  8'd0);
    cyc("c4",  8'h03, NOP, 1'b1, S_RUN, 8'd1);
    cyc("c5",  8'h04, LD3, 1'b0, S_LD,  8'd1);
    cyc("c6",  8'h04, NOP, 1'b1, S_RUN, 8'd2);
    cyc("c7",  8'h05, A4,  1'b0, S_RUN, 8'd2);
    // unconditional jump, no bubble
    cyc("c8",  8'h40, J40, 1'b0, S_RUN, 8'd2);
    cyc("c9",  8'h41, A40, 1'b0, S_RUN, 8'd2);
    cyc("c10", 8'h07, J07, 1'b0, S_RUN, 8'd2);
    // conditional jump taken
    cyc("c11", 8'h07, CJ,  1'b0, S_B1,  8'd2);
    cyc("c12", 8'h07, NOP, 1'b1, S_B2,  8'd3);
    br_taken  = 1'b1;
    br_target = 8'h20;
    cyc("c13", 8'h20, NOP, 1'b1, S_RUN, 8'd4);
    br_taken  = 1'b1;
    br_target = 8'h66;
    cyc("c14", 8'h07, J07, 1'b0, S_RUN, 8'd4);
    // conditional jump not taken
    cyc("c15", 8'h07, CJ,  1'b0, S_B1,  8'd4);
    cyc("c16", 8'h07, NOP, 1'b1, S_B2,  8'd5);
    br_taken  = 1'b0;
    br_target = 8'h55;
    cyc("c17", 8'h08, NOP, 1'b1, S_RUN, 8'd6);
    cyc("c18", 8'h07, J07, 1'b0, S_RUN, 8'd6);
    cyc("c19", 8'h07, CJ,  1'b0, S_B1,  8'd6);
    cyc("c20", 8'h07, NOP, 1'b1, S_B2,  8'd7);
    // hold in BR_WAIT2 defers resolution
    hold      = 1'b1;
    br_taken  = 1'b1;
    br_target = 8'h33;
    cyc("h1",  8'h07, NOP, 1'b1, S_B2,  8'd7);
    cyc("h2",  8'h07, NOP, 1'b1, S_B2,  8'd7);
    cyc("h3",  8'h07, NOP, 1'b1, S_B2,  8'd7);
    hold      = 1'b0;
    br_target = 8'hFF;
    cyc("c24", 8'hFF, NOP, 1'b1, S_RUN, 8'd8);
    // pc wraps 0xFF -> 0x00
    cyc("c25", 8'h00, AFF, 1'b0, S_RUN, 8'd8);
    cyc("c26", 8'h01, A0,  1'b0, S_RUN, 8'd8);
    // hold in RUN
    hold = 1'b1;
    cyc("h4",  8'h01, A0,  1'b0, S_RUN, 8'd8);
    hold = 1'b0;
    cyc("c27", 8'h02, A1,  1'b0, S_RUN, 8'd8);
    cyc("c28", 8'h03, LD2, 1'b0, S_LD,  8'd8);
    // reset mid-LD_BUB takes effect immediately
    reset = 1'b0;
    #1;
    check_all("arst", 8'h00, NOP, 1'b0, S_RUN, 8'd0);
    cyc("rst_hold", 8'h00, NOP, 1'b0, S_RUN, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc("rel", 8'h01, A0, 1'b0, S_RUN, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
